// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths and FSM state type for the 26/11 divider
package div_pkg;

    localparam int ASIZE_DEF = 26;
    localparam int BSIZE_DEF = 11;
    localparam int QSIZE_DEF = ASIZE_DEF - BSIZE_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_26_11_if.sv
// rtl/div_26_11_if.sv - operand/result handshake bundle; port r exists only with DIV_REM_EN
interface div_26_11_if #(
    parameter int ASIZE = div_pkg::ASIZE_DEF,
    parameter int BSIZE = div_pkg::BSIZE_DEF
);
    localparam int QSIZE = ASIZE - BSIZE;

    logic             in_valid;
    logic             in_ready;
    logic [ASIZE-1:0] a;
    logic [BSIZE-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [QSIZE-1:0] q;
`ifdef DIV_REM_EN
    logic [BSIZE-1:0] r;
`endif
    logic             dz;
    logic             ovf;

`ifdef DIV_REM_EN
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, q, r, dz, ovf);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, q, r, dz, ovf);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, q, dz, ovf);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, q, dz, ovf);
`endif

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, trial subtract, pick quotient bit
module div_step #(
    parameter int BSIZE = 11
) (
    input  logic [BSIZE-1:0] rem_in,
    input  logic             bit_in,
    input  logic [BSIZE-1:0] divisor,
    output logic [BSIZE-1:0] rem_out,
    output logic             q_bit
);

    logic [BSIZE:0] trial;
    logic [BSIZE:0] diff;

    // Partial remainder stays below the divisor, so the kept result always fits BSIZE bits
    always_comb begin
        trial   = {rem_in, bit_in};
        diff    = trial - {1'b0, divisor};
        q_bit   = (trial >= {1'b0, divisor});
        rem_out = q_bit ? diff[BSIZE-1:0] : trial[BSIZE-1:0];
    end

endmodule

// File: rtl/div_26_11.sv
// rtl/div_26_11.sv - sequential restoring divider, 26-bit / 11-bit; DIV_REM_EN adds remainder output
module div_26_11
    import div_pkg::*;
#(
    parameter int ASIZE = ASIZE_DEF,
    parameter int BSIZE = BSIZE_DEF
) (
    input logic         clk,
    input logic         rst_n,
    input logic         ce,
    div_26_11_if.slave  bus
);

    localparam int QSIZE = ASIZE - BSIZE;
    localparam int CW    = $clog2(QSIZE);

    state_t           state, state_nxt;
    logic             setup;
    logic [CW-1:0]    cnt;
    logic [BSIZE-1:0] b_reg;
    logic [BSIZE-1:0] rem;
    logic [QSIZE-1:0] a_lo;
    logic [QSIZE-1:0] q_reg;
    logic             dz_reg;
    logic             ovf_reg;
    logic             flag_dz;
    logic             flag_ovf;
    logic             last;
    logic [BSIZE-1:0] rem_nxt;
    logic             q_bit;
`ifdef DIV_REM_EN
    logic [BSIZE-1:0] r_reg;
`endif

    // rem holds the upper dividend bits right after accept, so the overflow test is a plain compare
    assign flag_dz  = (b_reg == '0);
    assign flag_ovf = !flag_dz && (rem >= b_reg);
    assign last     = (cnt == CW'(QSIZE - 1));

    div_step #(.BSIZE(BSIZE)) u_step (
        .rem_in  (rem),
        .bit_in  (a_lo[QSIZE-1]),
        .divisor (b_reg),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else if (ce)
            state <= state_nxt;
    end

    // Next state: first CALC cycle resolves flagged cases, then QSIZE iterations
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_nxt = ST_CALC;
            ST_CALC: begin
                if (setup) begin
                    if (flag_dz || flag_ovf) state_nxt = ST_DONE;
                end else if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, flag resolution, one quotient bit per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setup   <= 1'b0;
            cnt     <= '0;
            b_reg   <= '0;
            rem     <= '0;
            a_lo    <= '0;
            q_reg   <= '0;
            dz_reg  <= 1'b0;
            ovf_reg <= 1'b0;
`ifdef DIV_REM_EN
            r_reg   <= '0;
`endif
        end else if (ce) begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        b_reg <= bus.b;
                        rem   <= bus.a[ASIZE-1:QSIZE];
                        a_lo  <= bus.a[QSIZE-1:0];
                        setup <= 1'b1;
                        cnt   <= '0;
                    end
                end
                ST_CALC: begin
                    if (setup) begin
                        setup   <= 1'b0;
                        dz_reg  <= flag_dz;
                        ovf_reg <= flag_ovf;
                        q_reg   <= (flag_dz || flag_ovf) ? '1 : '0;
`ifdef DIV_REM_EN
                        if (flag_dz || flag_ovf) r_reg <= '0;
`endif
                    end else begin
                        rem   <= rem_nxt;
                        a_lo  <= {a_lo[QSIZE-2:0], 1'b0};
                        q_reg <= {q_reg[QSIZE-2:0], q_bit};
                        cnt   <= last ? '0 : cnt + CW'(1);
`ifdef DIV_REM_EN
                        if (last) r_reg <= rem_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.q         = q_reg;
    assign bus.dz        = dz_reg;
    assign bus.ovf       = ovf_reg;
`ifdef DIV_REM_EN
    assign bus.r         = r_reg;
`endif

endmodule
